// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: immediate-extension mode encodings and default widths.
package mips_pkg;

  localparam int MODE_W     = 3;
  localparam int WL_DEFAULT = 32;

  localparam logic [MODE_W-1:0] MODE_SIGN   = 3'b000;
  localparam logic [MODE_W-1:0] MODE_ZERO   = 3'b001;
  localparam logic [MODE_W-1:0] MODE_LUI    = 3'b010;
  localparam logic [MODE_W-1:0] MODE_BRANCH = 3'b011;

  // Every encoding with the top bit set is reserved.
  function automatic logic isIllegalMode(input logic [MODE_W-1:0] mode);
    return mode[MODE_W-1];
  endfunction

endpackage

// File: rtl/imm_ext_fifo.sv
// DEPTH-entry synchronous buffer with wrapping pointers and an occupancy count.
module imm_ext_fifo #(
  parameter int DEPTH = 2,
  parameter int PW    = 38
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [PW-1:0] wrData_i,
  output logic [PW-1:0] rdData_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [PW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wrPtr_q, wrPtr_d;
  logic [AW-1:0]   rdPtr_q, rdPtr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            doPush, doPop;

  assign full_o   = (count_q == CNTW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign doPush   = push_i & ~full_o;
  assign doPop    = pop_i & ~empty_o;
  assign rdData_o = mem_q[rdPtr_q];

  // DEPTH is a power of two, so plain increments wrap the pointers.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= wrData_i;
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension unit: extends at accept time and buffers results
// so decode can run ahead of the ALU/branch-target stages during stalls.
module imm_ext_pipe
  import mips_pkg::*;
#(
  parameter int WL    = WL_DEFAULT,
  parameter int IW    = 16,
  parameter int DEPTH = 2,
  parameter int TW    = 5,
  parameter int CW    = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              InValid,
  output logic              InReady,
  input  logic [IW-1:0]     Imm,
  input  logic [MODE_W-1:0] Mode,
  input  logic [TW-1:0]     InTag,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [WL-1:0]     SImm,
  output logic [TW-1:0]     OutTag,
  output logic              OutErr,
  output logic [CW-1:0]     ErrCnt
);

  localparam int PW = WL + TW + 1;

  logic [WL-1:0] signExt;
  logic [WL-1:0] extVal;
  logic          extErr;
  logic          accept;
  logic          fifoFull, fifoEmpty;
  logic [PW-1:0] headData;
  logic [CW-1:0] errCnt_q, errCnt_d;

  always_comb begin
    signExt = {{(WL-IW){Imm[IW-1]}}, Imm};
    extVal  = '0;
    extErr  = 1'b0;
    case (Mode)
      MODE_SIGN:   extVal = signExt;
      MODE_ZERO:   extVal = {{(WL-IW){1'b0}}, Imm};
      MODE_LUI:    extVal = {Imm, {(WL-IW){1'b0}}};
      MODE_BRANCH: extVal = {signExt[WL-3:0], 2'b00};
      default:     extErr = 1'b1;
    endcase
  end

  assign accept   = InValid & InReady;
  assign InReady  = ~fifoFull;
  assign OutValid = ~fifoEmpty;

  imm_ext_fifo #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_fifo (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .push_i   (accept),
    .pop_i    (OutReady),
    .wrData_i ({extVal, InTag, extErr}),
    .rdData_o (headData),
    .full_o   (fifoFull),
    .empty_o  (fifoEmpty)
  );

  // Buffer storage is never reset, so the head is masked until it holds a real entry.
  assign SImm   = OutValid ? headData[PW-1 -: WL] : '0;
  assign OutTag = OutValid ? headData[TW:1]       : '0;
  assign OutErr = OutValid & headData[0];
  assign ErrCnt = errCnt_q;

  always_comb begin
    errCnt_d = errCnt_q;
    if (accept && isIllegalMode(Mode) && (errCnt_q != '1)) errCnt_d = errCnt_q + CW'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) errCnt_q <= '0;
    else        errCnt_q <= errCnt_d;
  end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Pipelined, parametrised immediate-extension unit for the MIPS datapath.
- Takes an IW-bit immediate plus an extension mode and produces a WL-bit operand. Modes are sign-extend, zero-extend, LUI upper-load and branch-offset (sign-extend, shifted left 2).
- Results pass through a DEPTH-entry buffer with valid/ready handshakes on both sides. This lets decode run ahead of the ALU/branch-target stages when the pipelined core stalls.
- Illegal modes are flagged and counted.

Parameters:
- WL, 32: output word length; must satisfy WL > IW + 2.
- IW, 16: immediate input width.
- DEPTH, 2: buffer entries; power of two, at least 2.
- TW, 5: tag width; the tag carries the destination register number through the buffer unchanged.
- CW, 8: error-counter width.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- InValid  in  1  input request valid.
- InReady  out  1  unit can accept a request this cycle.
- Imm  in  IW  immediate field.
- Mode  in  3  extension mode: 000 SIGN, 001 ZERO, 010 LUI, 011 BRANCH; 1xx is illegal.
- InTag  in  TW  request tag.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts the result.
- SImm  out  WL  extended result.
- OutTag  out  TW  tag of the result.
- OutErr  out  1  result came from an illegal mode.
- ErrCnt  out  CW  saturating count of illegal-mode requests accepted.

Behaviour:
- Reset (RST_N low, asynchronous): read and write pointers and occupancy count go to 0. Outputs take these values:
  - OutValid = 0, InReady = 1, OutErr = 0, ErrCnt = 0, SImm = 0, OutTag = 0.
  - The buffer contents are don't-care.
  - Reset mid-operation discards all buffered entries. Any in-flight handshake that coincides with reset assertion is lost.
- Accept: on a rising edge with InValid & InReady, compute the result and write {SImm, InTag, err} into the tail entry.
- Pop: on a rising edge with OutValid & OutReady, advance the head.
- Result arithmetic, fixed at accept time:
  - SIGN: replicate Imm[IW-1] into the upper WL-IW bits, with Imm in the low IW bits. The sign bit is always the MSB of Imm.
  - ZERO: zeros in the upper bits, Imm in the low bits.
  - LUI: Imm placed at bits [WL-1:WL-IW], zeros below.
  - BRANCH: the SIGN result shifted left 2; the two low bits are 0 and the top two sign bits are discarded.
  - Illegal mode: result 0, err = 1.
- Latency: a request accepted at edge k gives OutValid = 1 after edge k. There is no combinational bypass from Imm to SImm.
- Output signals:
  - OutValid = (count != 0).
  - SImm, OutTag and OutErr are driven from the head entry and are stable while OutValid & !OutReady.
- InReady = (count != DEPTH). InReady is purely registered-state based, with no combinational path from OutReady.
- Full with simultaneous pop: InReady is still 0 that cycle, so there is no push. InReady rises the cycle after the pop.
- Not full with push and pop on the same edge: count is unchanged and both pointers advance.
- Empty with push and no pop: count becomes 1 and the result is visible the next cycle.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- ErrCnt increments on accept of an illegal mode and saturates at all-ones.
- All outputs come from flops or buffer reads. There are no latches.

Decomposition:
- Shared package mips_pkg holds:
  - the mode localparams MODE_SIGN, MODE_ZERO, MODE_LUI, MODE_BRANCH;
  - the mode width of 3;
  - the default WL of 32.
- One sub-module, imm_ext_fifo: a parametrised DEPTH-entry synchronous buffer with pointer and count logic, storing a (WL+TW+1)-bit payload.
- The extension mux stays in the top level as an always @(*) block.

Test Plan:
- Directed modes with OutReady = 1 and WL = 32, IW = 16. Expected results, each one cycle after its accept:
  - SIGN 16'h8000 gives 32'hFFFF8000.
  - SIGN 16'h4000 gives 32'h00004000, which checks that the MSB (not bit 14) is the sign bit.
  - ZERO 16'h8000 gives 32'h00008000.
  - LUI 16'h1234 gives 32'h12340000.
  - BRANCH 16'hFFFF gives 32'hFFFFFFFC.
  - BRANCH 16'h0003 gives 32'h0000000C.
- Backpressure: with OutReady = 0, send tags 1, 2, 3 back-to-back.
  - InReady drops after the second accept; tag 3 is held.
  - After OutReady rises, outputs appear in order 1, 2, 3 with no loss and no duplication.
- Simultaneous push and pop at count 1 for 20 cycles: count stays 1, pointers wrap, and the tag order is preserved.
- Illegal mode 3'b101 with Imm 16'hFFFF: SImm = 0, OutErr = 1, ErrCnt 0 to 1. Forcing 300 illegal requests saturates ErrCnt at 8'hFF.
- Reset mid-stream: assert RST_N low asynchronously (between edges) with 2 entries buffered.
  - OutValid = 0 and InReady = 1 immediately.
  - After release, the next request's result is the first one output.
- Parameter sweep at WL = 64, IW = 16, DEPTH = 4: SIGN 16'h8000 gives 64'hFFFFFFFFFFFF8000, and the unit accepts 4 entries before InReady drops.
